// File: rtl/rls_pkg.sv
// rls_pkg: shared RLS defaults and the sample feeder state encoding.
package rls_pkg;

    localparam int NBITS     = 32;
    localparam int FRAC_BITS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/rls_sync_fifo.sv
// rls_sync_fifo: single-clock FIFO, power-of-two depth, combinational head read.
module rls_sync_fifo
    import rls_pkg::*;
#(
    parameter int WIDTH = NBITS,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    // Push is refused when full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;

endmodule

// File: rtl/rls_sample_feeder.sv
// rls_sample_feeder: buffers samples and issues one RLS iteration per sample, GAP cycles apart.
// Optional RLS_FEEDER_STATS_EN adds the iters output counting newIt pulses.
module rls_sample_feeder
    import rls_pkg::*;
#(
    parameter int nBits = NBITS,
    parameter int DEPTH = 4,
    parameter int GAP   = 60
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [nBits-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [nBits-1:0]           y,
    output logic                       newIt,
    input  logic                       enable,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
`ifdef RLS_FEEDER_STATS_EN
    ,
    output logic [15:0]                iters
`endif
);

    localparam int WW = $clog2(GAP+1);
    // ISSUE + WAIT cycles + one IDLE cycle add up to GAP start-to-start.
    localparam logic [WW-1:0] WAIT_LOAD = WW'(GAP-3);

    feeder_state_e    state_q, state_d;
    logic [nBits-1:0] y_q, y_d, head;
    logic [WW-1:0]    wait_q, wait_d;
    logic             full, empty, load;

    rls_sync_fifo #(
        .WIDTH (nBits),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid),
        .pop   (load),
        .wdata (s_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign load = state_q == IDLE && !empty && enable;

    always_comb begin
        state_d = load ? ISSUE :
                  state_q == ISSUE ? WAIT :
                  (state_q == WAIT && wait_q == '0) ? IDLE : state_q;
        wait_d  = state_q == ISSUE ? WAIT_LOAD :
                  (state_q == WAIT && wait_q != '0) ? wait_q - WW'(1) : wait_q;
        y_d     = load ? head : y_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            y_q     <= y_d;
        end
    end

    assign s_ready = !full;
    assign y       = y_q;
    assign newIt   = state_q == ISSUE;
    assign busy    = state_q != IDLE;

`ifdef RLS_FEEDER_STATS_EN
    logic [15:0] iters_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) iters_q <= '0;
        else        iters_q <= iters_q + 16'(state_q == ISSUE);
    end
    assign iters = iters_q;
`else
    // Without statistics there is no iteration counter.
`endif

endmodule

// File: doc/rls_sample_feeder.md
RLS_SAMPLE_FEEDER -- requirements
Module: rls_sample_feeder

Interface
REQ-001 SHALL have parameter nBits, default 32: sample width, signed fixed point Q17.15 (15 fraction bits).
REQ-002 SHALL have parameter DEPTH, default 4: sample buffer entries, a power of two, at least 2.
REQ-003 SHALL have parameter GAP, default 60: minimum cycles from one newIt pulse to the next (start-to-start), at least 3.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_data  input  nBits  measurement sample from the acquisition side.
REQ-007 SHALL have port s_valid  input  1  s_data is valid.
REQ-008 SHALL have port s_ready  output  1  feeder can accept a sample.
REQ-009 SHALL have port y  output  nBits  current measurement to the RLS core.
REQ-010 SHALL have port newIt  output  1  one-cycle pulse that starts one RLS iteration on y.
REQ-011 SHALL have port enable  input  1  when low, no new iteration is issued; buffering continues.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of buffered samples.
REQ-013 SHALL have port busy  output  1  high in ISSUE or WAIT.

Function
REQ-014 SHALL accept a sample on a rising edge where s_valid and s_ready are both high, and write it to the FIFO tail.
REQ-015 SHALL drive s_ready = (count != DEPTH) from registered state, so no sample is accepted when full, even in a pop cycle.
REQ-016 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-017 SHALL, in IDLE with count > 0 and enable high, load y from the FIFO head, pop it, and move to ISSUE on the next edge.
REQ-018 SHALL assert newIt only in ISSUE, for exactly one cycle, and then go to WAIT.
REQ-019 SHALL, in WAIT, count down so that the next ISSUE starts no earlier than GAP cycles after the previous one, then return to IDLE.
REQ-020 SHALL give GAP-cycle start-to-start spacing when the FIFO stays non-empty and enable stays high.
REQ-021 SHALL have a latency of 2 edges: a sample accepted at edge E0 into an empty FIFO, in IDLE with enable high, gives y updated at E1 and newIt high from E1 to E2.
REQ-022 SHALL hold y stable from one load until the next load.
REQ-023 SHALL, on a push and a pop in the same cycle, leave count unchanged and keep FIFO order.
REQ-024 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-025 SHALL sample enable only in IDLE; clearing enable in ISSUE or WAIT does not cancel that iteration.
REQ-026 SHALL pass data unchanged, with no arithmetic on the sample.

Reset
REQ-027 SHALL, on reset low, immediately clear: state=IDLE, y=0, newIt=0, busy=0, count=0, pointers=0, s_ready=1 (once reset is released), WAIT counter=0.
REQ-028 SHALL, on reset asserted mid-ISSUE or mid-WAIT, abort the iteration and discard the buffered samples.

Configuration
REQ-029 SHALL use macro RLS_FEEDER_STATS_EN; when defined, output iters [15:0] counts newIt pulses, wraps 0xFFFF to 0, and resets to 0.
REQ-030 SHALL, without RLS_FEEDER_STATS_EN, omit the iters port and its counter entirely.

Structure
REQ-031 SHALL take from shared package rls_pkg: the default NBITS=32, FRAC_BITS=15, and the feeder state enum (IDLE, ISSUE, WAIT).
REQ-032 SHALL place the buffer in one sub-module rls_sync_fifo, parameterised by width and depth, with full, empty and count outputs.

Verification
REQ-033 SHALL cover: reset release, push 0x00060000 (12.0) -> y=0x00060000 at E1, newIt high 1 cycle, count back to 0.
REQ-034 SHALL cover: push 0x00060000 then 0x00070000 back to back -> two newIt pulses exactly 60 cycles apart, y=0x00070000 after the second.
REQ-035 SHALL cover: enable=0, push 5 samples -> 4 accepted, s_ready=0, count=4; enable=1 -> 4 pulses in FIFO order at 60-cycle spacing.
REQ-036 SHALL cover: push/pop in the same cycle at count=2 -> count stays 2; pointer wrap after 9 samples keeps order.
REQ-037 SHALL cover: reset low in WAIT with count=3 -> immediately count=0, y=0, busy=0, no further newIt.
REQ-038 SHALL cover, with RLS_FEEDER_STATS_EN defined: 3 issued iterations -> iters=3; forced to 0xFFFF plus one issue -> iters=0.
